sdr_toggle_responder: RTL and testbench

- Memory-side responder for the sound subsystem's two toggle-handshake SDRAM channels.
- The CPU word channel carries 16-bit reads and byte-masked writes. The sample channel carries 64-bit reads.
- Serialises both channels onto one 16-bit, variable-latency memory command port. Sits between the sound block and the SDRAM controller port assigned to sound.

---
 rtl/sdr_toggle_responder.sv | 198 +++++++++++++++++++
 tb/tb_sdr_toggle_responder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_toggle_responder.sv
//-----------------------------------------------------------------------------
// sdr_toggle_responder
// Memory-side responder for the sound block's two toggle-handshake SDRAM
// channels. The CPU word channel (16-bit reads, byte-masked writes) and the
// sample channel (64-bit reads, fetched as four 16-bit words) are serialised
// onto one 16-bit variable-latency command port.
//
// Ports:
//   clk_sys, reset_n              clock, async active-low reset
//   cpu_addr/din/wr_sel/req       CPU request side (wr_sel 00 = read)
//   cpu_ack, cpu_dout             CPU acknowledge toggle, read data
//   smp_addr/req                  sample request side (8-byte aligned)
//   smp_ack, smp_data             sample acknowledge toggle, 64-bit data
//   mem_req/we/be/addr/wdata      command to memory (mem_req is a level)
//   mem_gnt                       command accepted this cycle
//   mem_rvalid, mem_rdata         in-order read return
//
// state    | meaning
// IDLE     | no command in flight, arbitrating between pending channels
// CPU_CMD  | CPU command presented, waiting for mem_gnt
// CPU_WAIT | CPU read granted, waiting for mem_rvalid
// SMP_CMD  | sample word command presented, waiting for mem_gnt
// SMP_WAIT | sample word granted, waiting for mem_rvalid
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module sdr_toggle_responder #(
    parameter bit          CPU_PRIO     = 1'b1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [24:0] cpu_addr,
    input  logic [15:0] cpu_din,
    input  logic [1:0]  cpu_wr_sel,
    input  logic        cpu_req,
    output logic        cpu_ack,
    output logic [15:0] cpu_dout,
    input  logic [24:0] smp_addr,
    input  logic        smp_req,
    output logic        smp_ack,
    output logic [63:0] smp_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [24:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_CMD,
        CPU_WAIT,
        SMP_CMD,
        SMP_WAIT
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t      r_state;
    logic        r_cpu_wr;
    logic [21:0] r_smp_base;
    logic [1:0]  r_widx;
    logic [47:0] r_shadow;
    logic [3:0]  r_starve;

    logic       w_cpu_pend;
    logic       w_smp_pend;
    logic       w_pick_smp;
    logic [3:0] w_starve_cpu_done;
    logic       w_unused_bits;

    assign w_cpu_pend = cpu_req ^ cpu_ack;
    assign w_smp_pend = smp_req ^ smp_ack;

    // With both pending the priority channel wins, except that a CPU-priority
    // configuration yields to the sample channel once the starve count is full.
    always_comb begin
        w_pick_smp = 1'b0;
        if (w_cpu_pend && w_smp_pend) begin
            if (CPU_PRIO)
                w_pick_smp = (r_starve == STARVE_MAX);
            else
                w_pick_smp = 1'b1;
        end else begin
            w_pick_smp = w_smp_pend;
        end
    end

    // Starve count after a CPU completion: counts only while sample waits.
    always_comb begin
        w_starve_cpu_done = 4'd0;
        if (w_smp_pend)
            w_starve_cpu_done = (r_starve == STARVE_MAX) ? STARVE_MAX : r_starve + 4'd1;
    end

    assign w_unused_bits = ^{cpu_addr[0], smp_addr[2:0]};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cpu_wr   <= 1'b0;
            r_smp_base <= '0;
            r_widx     <= '0;
            r_shadow   <= '0;
            r_starve   <= '0;
            cpu_ack    <= 1'b0;
            cpu_dout   <= '0;
            smp_ack    <= 1'b0;
            smp_data   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_smp) begin
                        r_smp_base <= smp_addr[24:3];
                        r_widx     <= 2'd0;
                        r_starve   <= 4'd0;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_be     <= 2'b11;
                        mem_addr   <= {smp_addr[24:3], 2'd0, 1'b0};
                        r_state    <= SMP_CMD;
                    end else if (w_cpu_pend) begin
                        r_cpu_wr  <= (cpu_wr_sel != 2'b00);
                        mem_req   <= 1'b1;
                        mem_we    <= (cpu_wr_sel != 2'b00);
                        mem_be    <= (cpu_wr_sel != 2'b00) ? cpu_wr_sel : 2'b11;
                        mem_addr  <= {cpu_addr[24:1], 1'b0};
                        mem_wdata <= cpu_din;
                        r_state   <= CPU_CMD;
                    end
                end

                CPU_CMD: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (r_cpu_wr) begin
                            cpu_ack  <= ~cpu_ack;
                            r_starve <= w_starve_cpu_done;
                            r_state  <= IDLE;
                        end else begin
                            r_state <= CPU_WAIT;
                        end
                    end
                end

                CPU_WAIT: begin
                    if (mem_rvalid) begin
                        cpu_dout <= mem_rdata;
                        cpu_ack  <= ~cpu_ack;
                        r_starve <= w_starve_cpu_done;
                        r_state  <= IDLE;
                    end
                end

                SMP_CMD: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        r_state <= SMP_WAIT;
                    end
                end

                SMP_WAIT: begin
                    if (mem_rvalid) begin
                        if (r_widx == 2'd3) begin
                            // Publish all four words together so smp_data only
                            // ever moves alongside the acknowledge toggle.
                            smp_data <= {mem_rdata, r_shadow};
                            smp_ack  <= ~smp_ack;
                            r_state  <= IDLE;
                        end else begin
                            case (r_widx)
                                2'd0:    r_shadow[15:0]  <= mem_rdata;
                                2'd1:    r_shadow[31:16] <= mem_rdata;
                                default: r_shadow[47:32] <= mem_rdata;
                            endcase
                            r_widx   <= r_widx + 2'd1;
                            mem_req  <= 1'b1;
                            mem_addr <= {r_smp_base, r_widx + 2'd1, 1'b0};
                            r_state  <= SMP_CMD;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_toggle_responder.sv
`timescale 1ns/1ps

module tb_sdr_toggle_responder;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [24:0] cpu_addr = '0;
    logic [15:0] cpu_din = '0;
    logic [1:0]  cpu_wr_sel = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_ack;
    logic [15:0] cpu_dout;
    logic [24:0] smp_addr = '0;
    logic        smp_req = 1'b0;
    logic        smp_ack;
    logic [63:0] smp_data;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_be;
    logic [24:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    sdr_toggle_responder #(
        .CPU_PRIO     (1'b1),
        .STARVE_LIMIT (2)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_wr_sel (cpu_wr_sel),
        .cpu_req    (cpu_req),
        .cpu_ack    (cpu_ack),
        .cpu_dout   (cpu_dout),
        .smp_addr   (smp_addr),
        .smp_req    (smp_req),
        .smp_ack    (smp_ack),
        .smp_data   (smp_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #12 clk_sys = ~clk_sys;

    logic [127:0] w_outs;
    assign w_outs = {1'b0, cpu_ack, cpu_dout, smp_ack, smp_data, mem_req,
                     mem_we, mem_be, mem_addr, mem_wdata};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Backend model: grants after gnt_dly cycles, returns read data rv_dly
    // cycles after the grant. Data is derived from the address.
    logic        be_en   = 1'b0;
    int          gnt_dly = 0;
    int          rv_dly  = 1;
    logic [24:0] addr_log[$];

    function automatic logic [15:0] be_data(input logic [24:0] a);
        return (a == 25'h100000) ? 16'h1234 : (16'hA000 | {14'd0, a[2:1]});
    endfunction

    initial begin : backend
        logic [24:0] a;
        logic        we;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk_sys);
            if (be_en && mem_req) begin
                repeat (gnt_dly) @(negedge clk_sys);
                a  = mem_addr;
                we = mem_we;
                addr_log.push_back(a);
                mem_gnt = 1'b1;
                @(negedge clk_sys);
                mem_gnt = 1'b0;
                if (!we) begin
                    repeat (rv_dly - 1) @(negedge clk_sys);
                    mem_rvalid = 1'b1;
                    mem_rdata  = be_data(a);
                    @(negedge clk_sys);
                    mem_rvalid = 1'b0;
                    mem_rdata  = '0;
                end
            end
        end
    end

    logic mon_en = 1'b0;
    byte  order_q[$];

    initial begin : ack_monitor
        logic pc, ps;
        pc = 1'b0;
        ps = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (mon_en && cpu_ack !== pc) order_q.push_back("C");
            if (mon_en && smp_ack !== ps) order_q.push_back("S");
            pc = cpu_ack;
            ps = smp_ack;
        end
    end

    // Waits (bounded) until the selected channel is no longer pending.
    task automatic wait_done(input bit smp, output int n, output bit moved);
        logic [63:0] snap;
        snap  = smp_data;
        moved = 1'b0;
        n     = 0;
        for (int i = 0; i < 200; i++) begin
            if (smp ? (smp_req == smp_ack) : (cpu_req == cpu_ack)) break;
            @(negedge clk_sys);
            n++;
            if (smp && smp_req != smp_ack && smp_data != snap) moved = 1'b1;
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
    endtask

    initial begin : main
        int          n;
        bit          moved;
        bit          ok;
        logic        acc;
        logic [127:0] acc_outs;
        logic [47:0] ord;
        logic [47:0] exp_ord;

        // Reset and idle
        #5;
        check("rst_outs", w_outs, 128'd0);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_sys);
            acc = acc | mem_req;
        end
        check("idle_mem_req", acc, 1'b0);
        check("idle_outs", w_outs, 128'd0);

        be_en = 1'b1;

        // CPU write, grant after 3 cycles
        gnt_dly    = 3;
        rv_dly     = 1;
        cpu_addr   = 25'h0A0013;
        cpu_din    = 16'hBEEF;
        cpu_wr_sel = 2'b10;
        cpu_req    = ~cpu_req;
        @(negedge clk_sys);
        check("wr_mem_req", mem_req, 1'b1);
        check("wr_mem_addr", mem_addr, 25'h0A0012);
        check("wr_mem_be", mem_be, 2'b10);
        check("wr_mem_we", mem_we, 1'b1);
        check("wr_mem_wdata", mem_wdata, 16'hBEEF);
        wait_done(1'b0, n, moved);
        check("wr_latency", n, 4);
        check("wr_req_drop", mem_req, 1'b0);
        check("wr_ack", cpu_ack, 1'b1);
        repeat (3) @(negedge clk_sys);

        // CPU read, rvalid 5 cycles after grant
        gnt_dly    = 0;
        rv_dly     = 5;
        cpu_addr   = 25'h100000;
        cpu_wr_sel = 2'b00;
        cpu_req    = ~cpu_req;
        @(negedge clk_sys);
        check("rd_mem_addr", mem_addr, 25'h100000);
        check("rd_mem_we", mem_we, 1'b0);
        check("rd_mem_be", mem_be, 2'b11);
        wait_done(1'b0, n, moved);
        check("rd_latency", n, 6);
        check("rd_dout", cpu_dout, 16'h1234);
        repeat (3) @(negedge clk_sys);

        // CPU read at minimum latency
        rv_dly   = 1;
        cpu_addr = 25'h000047;
        cpu_req  = ~cpu_req;
        @(negedge clk_sys);
        check("minrd_mem_addr", mem_addr, 25'h000046);
        wait_done(1'b0, n, moved);
        check("minrd_latency", n, 2);
        check("minrd_dout", cpu_dout, 16'hA003);
        repeat (3) @(negedge clk_sys);

        // Sample read of four words
        addr_log.delete();
        smp_addr = 25'h20000D;
        smp_req  = ~smp_req;
        @(negedge clk_sys);
        check("smp_first_addr", mem_addr, 25'h200008);
        wait_done(1'b1, n, moved);
        check("smp_ack", smp_ack, smp_req);
        check("smp_latency_ge8", (n >= 8 && n < 200), 1'b1);
        check("smp_data_stable", moved, 1'b0);
        check("smp_data", smp_data, 64'hA003A002A001A000);
        check("smp_n_cmds", addr_log.size(), 4);
        for (int k = 0; k < 4 && k < addr_log.size(); k++)
            check($sformatf("smp_addr%0d", k), addr_log[k], 25'h200008 + 25'(2 * k));
        repeat (3) @(negedge clk_sys);

        // Arbitration: CPU re-requests continuously while sample is pending
        mon_en = 1'b1;
        @(negedge clk_sys);
        fork
            begin : cpu_requester
                int nc;
                bit mc;
                for (int k = 0; k < 4; k++) begin
                    cpu_addr   = 25'h000200 | 25'(k << 2);
                    cpu_wr_sel = 2'b00;
                    cpu_req    = ~cpu_req;
                    wait_done(1'b0, nc, mc);
                end
            end
            begin : smp_requester
                int ns;
                bit ms;
                for (int k = 0; k < 2; k++) begin
                    smp_addr = 25'h040000 | 25'(k << 3);
                    smp_req  = ~smp_req;
                    wait_done(1'b1, ns, ms);
                end
            end
        join
        repeat (2) @(negedge clk_sys);
        mon_en = 1'b0;
        ord = '0;
        for (int i = 0; i < order_q.size() && i < 6; i++)
            ord = {ord[39:0], order_q[i]};
        exp_ord = "CCSCCS";
        check("arb_count", order_q.size(), 6);
        check("arb_order", ord, exp_ord);
        repeat (3) @(negedge clk_sys);

        // Reset in SMP_WAIT after two words, then a stray rvalid
        be_en = 1'b0;
        repeat (3) @(negedge clk_sys);
        smp_addr = 25'h300010;
        smp_req  = ~smp_req;
        for (int w = 0; w < 2; w++) begin
            wait_req(ok);
            check($sformatf("rst_req_seen%0d", w), ok, 1'b1);
            mem_gnt = 1'b1;
            @(negedge clk_sys);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = 16'h5555;
            @(negedge clk_sys);
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        wait_req(ok);
        check("rst_req_seen2", ok, 1'b1);
        check("rst_word2_addr", mem_addr, 25'h300014);
        mem_gnt = 1'b1;
        @(negedge clk_sys);
        mem_gnt = 1'b0;
        check("rst_in_wait", mem_req, 1'b0);
        reset_n = 1'b0;
        cpu_req = 1'b0;
        smp_req = 1'b0;
        #1;
        check("rst_async_outs", w_outs, 128'd0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hDEAD;
        @(negedge clk_sys);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        acc_outs = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_sys);
            acc_outs = acc_outs | w_outs;
        end
        check("rst_rvalid_ignored", acc_outs, 128'd0);

        // Fresh fetch after reset
        be_en = 1'b1;
        gnt_dly = 0;
        rv_dly  = 1;
        addr_log.delete();
        smp_req = ~smp_req;
        @(negedge clk_sys);
        wait_done(1'b1, n, moved);
        check("post_rst_ack", smp_ack, 1'b1);
        check("post_rst_data", smp_data, 64'hA003A002A001A000);
        check("post_rst_n_cmds", addr_log.size(), 4);
        if (addr_log.size() > 0)
            check("post_rst_addr0", addr_log[0], 25'h300010);

        repeat (3) @(negedge clk_sys);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
